// File: rtl/gauss3x3_stream_core.sv
// Streaming 3x3 Gaussian (1-2-1) filter: fetches pixels in raster order by address,
// keeps the two previous rows in line buffers and writes back filtered interior pixels.
module gauss3x3_stream_core #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              finish
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = ADDR_W - CW;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg;

  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];
  logic [7:0]    lb1_rd_reg;
  logic [7:0]    lb2_rd_reg;

  logic [CW-1:0] col;
  logic [CW-1:0] rd_col;
  logic [RW-1:0] row;
  logic          capture;
  logic          produce;
  logic          last_px;

  // Window columns: win_reg[k][0] = column c-2, win_reg[k][1] = column c-1, new_col = column c.
  // Row index k: 0 = r-2 (top), 1 = r-1 (centre), 2 = r (bottom).
  logic [7:0]    win_reg [3][2];
  logic [7:0]    new_col [3];
  logic [9:0]    row_sum [3];
  logic [11:0]   sum;
  logic [11:0]   sum_rnd;

  assign col     = in_addr[CW-1:0];
  assign row     = in_addr[ADDR_W-1:CW];
  assign capture = in_valid && (state_reg != DONE);
  assign produce = capture && (row >= RW'(2)) && (col >= CW'(2));
  assign last_px = (in_addr == ADDR_W'(IMG_W * IMG_H - 1));

  // Read address runs one column ahead on a capture so the registered read
  // output is ready for the next pixel; it never collides with the write column.
  assign rd_col  = capture ? col + CW'(1) : col;

  assign new_col[0] = lb2_rd_reg;
  assign new_col[1] = lb1_rd_reg;
  assign new_col[2] = in_data;

  always_ff @(posedge clk) begin
    if (capture) begin
      lb1[col] <= in_data;
      lb2[col] <= lb1_rd_reg;
    end
    lb1_rd_reg <= lb1[rd_col];
    lb2_rd_reg <= lb2[rd_col];
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_win
    assign row_sum[gi] = 10'(win_reg[gi][0]) + {1'b0, win_reg[gi][1], 1'b0} + 10'(new_col[gi]);

    always_ff @(posedge clk) begin
      if (rst) begin
        win_reg[gi][0] <= 8'd0;
        win_reg[gi][1] <= 8'd0;
      end else if (capture) begin
        win_reg[gi][0] <= win_reg[gi][1];
        win_reg[gi][1] <= new_col[gi];
      end
    end
  end

  assign sum     = 12'(row_sum[0]) + {1'b0, row_sum[1], 1'b0} + 12'(row_sum[2]);
  assign sum_rnd = sum + 12'd8;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      in_addr   <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= 8'd0;
      finish    <= 1'b0;
    end else begin
      out_valid <= produce;
      if (produce) begin
        // Centre pixel is one row up and one column left of the capture.
        out_addr <= in_addr - ADDR_W'(IMG_W + 1);
        out_data <= sum_rnd[11:4];
      end
      case (state_reg)
        IDLE, RUN: begin
          if (capture) begin
            if (last_px) begin
              state_reg <= DONE;
              finish    <= 1'b1;
            end else begin
              state_reg <= RUN;
              in_addr   <= in_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gauss3x3_stream_core.sv
// Directed bench for gauss3x3_stream_core on a 16x16 image: flat, impulse, saturated,
// random, stalled and mid-run reset images checked against a direct 3x3 convolution.
module tb_gauss3x3_stream_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_addr;
  logic [7:0] in_data;
  logic       out_valid;
  logic [7:0] out_addr;
  logic [7:0] out_data;
  logic       finish;

  int asserts = 0;
  int fails   = 0;

  logic [7:0] img     [256];
  logic [7:0] res     [256];
  logic [7:0] ref_res [256];
  int         nres;
  int         last_addr;
  bit         aborted;

  gauss3x3_stream_core #(.IMG_W(16), .IMG_H(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
    .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Direct convolution over the stored image, independent of any streaming structure.
  function automatic int golden(input int a);
    int r, c, s, w;
    r = a / 16;
    c = a % 16;
    s = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        w = ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
        s += w * int'(img[(r + dr) * 16 + (c + dc)]);
      end
    end
    return (s + 8) / 16;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic stall(input string name, input int n, input logic [7:0] hold);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({name, " stall in_addr"}, in_addr, hold);
      chk({name, " stall out_valid"}, out_valid, 0);
    end
  endtask

  task automatic run_image(input string name, input bit stall_en, input bit rst_mid);
    int cyc;
    bit sa, sb;
    cyc = 0; sa = 0; sb = 0; nres = 0; last_addr = -1; aborted = 0;
    for (int i = 0; i < 256; i++) res[i] = 8'd0;
    in_data  = img[0];
    in_valid = 1'b1;
    while (finish !== 1'b1 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (out_valid === 1'b1) begin
        if (last_addr < 0) chk({name, " first addr"}, out_addr, 8'h11);
        else chk({name, " addr order"}, (int'(out_addr) > last_addr) ? 1 : 0, 1);
        chk({name, " data"}, out_data, golden(int'(out_addr)));
        res[out_addr] = out_data;
        last_addr = int'(out_addr);
        nres++;
      end
      if (finish === 1'b1) break;
      if (rst_mid && in_addr == 8'h90) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        chk({name, " rst in_addr"}, in_addr, 0);
        chk({name, " rst out_valid"}, out_valid, 0);
        chk({name, " rst finish"}, finish, 0);
        aborted = 1;
        $display("run %s: reset after %0d results", name, nres);
        return;
      end
      if (stall_en && !sa && in_addr == 8'h30) begin
        sa = 1;
        stall(name, 5, 8'h30);
      end
      if (stall_en && !sb && in_addr == 8'h4F) begin
        sb = 1;
        stall(name, 3, 8'h4F);
      end
      in_data  = img[in_addr];
      in_valid = 1'b1;
    end
    chk({name, " finish"}, finish, 1);
    chk({name, " count"}, nres, 196);
    chk({name, " last addr"}, last_addr, 8'hEE);
    for (int k = 0; k < 4; k++) begin
      in_valid = k[0];
      @(posedge clk); #1;
      chk({name, " post out_valid"}, out_valid, 0);
      chk({name, " post in_addr"}, in_addr, 8'hFF);
      chk({name, " post finish"}, finish, 1);
    end
    in_valid = 1'b0;
    $display("run %s: %0d results, last addr %0h", name, nres, last_addr);
  endtask

  initial begin
    int nz;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_addr", in_addr, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_addr", out_addr, 0);
    chk("reset out_data", out_data, 0);
    chk("reset finish", finish, 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) img[i] = 8'd100;
    run_image("flat", 0, 0);
    for (int r = 1; r < 15; r++)
      for (int c = 1; c < 15; c++)
        chk("flat value", res[r * 16 + c], 100);

    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'd0;
    img[8'h88] = 8'd255;
    run_image("impulse", 0, 0);
    chk("impulse centre", res[8'h88], 64);
    chk("impulse up", res[8'h78], 32);
    chk("impulse upleft", res[8'h77], 16);
    chk("impulse right", res[8'h89], 32);
    chk("impulse downright", res[8'h99], 16);
    nz = 0;
    for (int i = 0; i < 256; i++) if (res[i] != 8'd0) nz++;
    chk("impulse nonzero", nz, 9);

    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'd255;
    run_image("sat", 0, 0);
    chk("sat first", res[8'h11], 255);
    chk("sat last", res[8'hEE], 255);

    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
    run_image("random", 0, 0);
    for (int i = 0; i < 256; i++) ref_res[i] = res[i];

    do_reset();
    run_image("stall", 1, 0);
    for (int i = 0; i < 256; i++) chk("stall vs plain", res[i], ref_res[i]);

    do_reset();
    run_image("midrst", 0, 1);
    chk("midrst aborted", aborted, 1);
    run_image("rerun", 0, 0);
    for (int i = 0; i < 256; i++) chk("rerun vs plain", res[i], ref_res[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
